// File: rtl/cprv_pkg.sv
// Shared constants and types for the cprv64g memory stage.
package cprv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, MEM, SEND} mem_state_t;

  // Byte lane within the 8-byte word, forced to the access's natural alignment.
  function automatic logic [2:0] lane_off(input logic [2:0] addr_lo, input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return addr_lo;
      2'b01:   return {addr_lo[2:1], 1'b0};
      2'b10:   return {addr_lo[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/cprv_lsu_align.sv
// Byte-lane steering: store strobes/data shift and load shift/extension.
module cprv_lsu_align
  import cprv_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  input  logic [63:0] store_data,
  input  logic [63:0] load_word,
  output logic [7:0]  strb,
  output logic [63:0] wdata,
  output logic [63:0] rdata
);

  logic [63:0] shifted;

  // Lane shifts, strobe generation and load extension by access size.
  always_comb begin
    shifted = load_word >> {off, 3'b000};
    wdata   = store_data << {off, 3'b000};
    case (funct3[1:0])
      2'b00:   strb = 8'h01 << off;
      2'b01:   strb = 8'h03 << off;
      2'b10:   strb = 8'h0F << off;
      default: strb = 8'hFF;
    endcase
    case (funct3)
      F3_B:    rdata = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    rdata = shifted;
      F3_BU:   rdata = {56'd0, shifted[7:0]};
      F3_HU:   rdata = {48'd0, shifted[15:0]};
      F3_WU:   rdata = {32'd0, shifted[31:0]};
      default: rdata = 64'd0;
    endcase
  end

endmodule

// File: rtl/cprv_mem_stage.sv
// Memory-access stage: execute -> data memory -> writeback, one instruction in flight.
//
// state | meaning
// IDLE  | ready for a new instruction from execute
// MEM   | data-memory request outstanding, waiting for ack
// SEND  | result offered to writeback, waiting for ready
module cprv_mem_stage
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_mem_i,
  output logic                  ready_mem_o,
  input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
  input  logic [4:0]            rd_addr_mem_i,
  input  logic                  rd_en_mem_i,
  input  logic [6:0]            opcode_mem_i,
  input  logic [2:0]            funct3_mem_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [63:0]           dmem_wdata_o,
  output logic [7:0]            dmem_strb_o,
  input  logic                  dmem_ack_i,
  input  logic [63:0]           dmem_rdata_i,
  output logic                  valid_wb_o,
  input  logic                  ready_wb_i,
  output logic [4:0]            rd_addr_wb_o,
  output logic                  rd_en_wb_o,
  output logic [6:0]            opcode_wb_o,
  output logic [2:0]            funct3_wb_o,
  output logic [DATA_WIDTH-1:0] alu_out_wb_o,
  output logic [DATA_WIDTH-1:0] rdata_wb_o
);

  mem_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] rs2_q;
  logic [7:0]            strb_a;
  logic [63:0]           wdata_a;
  logic [63:0]           rdata_a;
  logic                  accept;
  logic                  is_store;

  assign accept   = (state_q == IDLE) && valid_mem_i;
  assign is_store = (opcode_wb_o == STORE);

  cprv_lsu_align u_align (
    .off        (lane_off(alu_out_wb_o[2:0], funct3_wb_o)),
    .funct3     (funct3_wb_o),
    .store_data (rs2_q),
    .load_word  (dmem_rdata_i),
    .strb       (strb_a),
    .wdata      (wdata_a),
    .rdata      (rdata_a)
  );

  // State register; reset drops any outstanding request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    ready_mem_o = 1'b0;
    dmem_req_o  = 1'b0;
    valid_wb_o  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_mem_o = 1'b1;
        if (valid_mem_i)
          state_d = (opcode_mem_i == LOAD || opcode_mem_i == STORE) ? MEM : SEND;
      end
      MEM: begin
        dmem_req_o = 1'b1;
        if (dmem_ack_i) state_d = SEND;
      end
      SEND: begin
        valid_wb_o = 1'b1;
        if (ready_wb_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields derive only from registered state, so they hold across stalls.
  assign dmem_we_o    = dmem_req_o && is_store;
  assign dmem_addr_o  = {alu_out_wb_o[ADDR_WIDTH-1:3], 3'b000};
  assign dmem_wdata_o = wdata_a;
  assign dmem_strb_o  = dmem_we_o ? strb_a : 8'h00;

  // Capture the instruction on accept and the extended load data on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_wb_o <= '0;
      rd_en_wb_o   <= 1'b0;
      opcode_wb_o  <= '0;
      funct3_wb_o  <= '0;
      alu_out_wb_o <= '0;
      rs2_q        <= '0;
      rdata_wb_o   <= '0;
    end else if (accept) begin
      rd_addr_wb_o <= rd_addr_mem_i;
      rd_en_wb_o   <= rd_en_mem_i && (opcode_mem_i != STORE);
      opcode_wb_o  <= opcode_mem_i;
      funct3_wb_o  <= funct3_mem_i;
      alu_out_wb_o <= alu_out_mem_i;
      rs2_q        <= rs2_data_mem_i;
      rdata_wb_o   <= '0;
    end else if (state_q == MEM && dmem_ack_i && opcode_wb_o == LOAD) begin
      rdata_wb_o <= rdata_a;
    end
  end

endmodule

// File: tb/tb_cprv_mem_stage.sv
// Directed and randomized checks of cprv_mem_stage against a byte-level model.
module tb_cprv_mem_stage;
  import cprv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_mem_i;
  logic        ready_mem_o;
  logic [63:0] alu_out_mem_i, rs2_data_mem_i;
  logic [4:0]  rd_addr_mem_i;
  logic        rd_en_mem_i;
  logic [6:0]  opcode_mem_i;
  logic [2:0]  funct3_mem_i;
  logic        dmem_req_o, dmem_we_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o;
  logic [7:0]  dmem_strb_o;
  logic        dmem_ack_i;
  logic [63:0] dmem_rdata_i;
  logic        valid_wb_o, ready_wb_i;
  logic [4:0]  rd_addr_wb_o;
  logic        rd_en_wb_o;
  logic [6:0]  opcode_wb_o;
  logic [2:0]  funct3_wb_o;
  logic [63:0] alu_out_wb_o, rdata_wb_o;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  cprv_mem_stage #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_mem_i(valid_mem_i), .ready_mem_o(ready_mem_o),
    .alu_out_mem_i(alu_out_mem_i), .rs2_data_mem_i(rs2_data_mem_i),
    .rd_addr_mem_i(rd_addr_mem_i), .rd_en_mem_i(rd_en_mem_i),
    .opcode_mem_i(opcode_mem_i), .funct3_mem_i(funct3_mem_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_strb_o(dmem_strb_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_wb_o(valid_wb_o), .ready_wb_i(ready_wb_i),
    .rd_addr_wb_o(rd_addr_wb_o), .rd_en_wb_o(rd_en_wb_o),
    .opcode_wb_o(opcode_wb_o), .funct3_wb_o(funct3_wb_o),
    .alu_out_wb_o(alu_out_wb_o), .rdata_wb_o(rdata_wb_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: access size in bytes and its naturally aligned lane.
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int acc_off(input logic [2:0] f3, input logic [63:0] addr);
    int sz;
    sz = acc_size(f3);
    return (int'(addr % 8) / sz) * sz;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [2:0] f3, input logic [63:0] addr);
    int m;
    m = ((1 << acc_size(f3)) - 1) << acc_off(f3, addr);
    return m[7:0];
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [2:0] f3, input logic [63:0] addr,
                                            input logic [63:0] rs2);
    return rs2 << (8 * acc_off(f3, addr));
  endfunction

  // Assemble the addressed bytes one at a time, then extend by the top byte's sign.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr,
                                           input logic [63:0] word);
    int sz, off;
    logic [63:0] v, b;
    if (f3 == 3'b111) return 64'd0;
    sz = acc_size(f3);
    off = acc_off(f3, addr);
    v = 64'd0;
    for (int i = 0; i < sz; i++) begin
      b = (word >> (8 * (off + i))) & 64'hFF;
      v = v | (b << (8 * i));
    end
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
    return v;
  endfunction

  task automatic do_txn(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] alu,
                        input logic [63:0] rs2, input logic [4:0] rd, input logic rden,
                        input logic [63:0] word, input int ack_dly, input int stall);
    logic        is_mem, is_st;
    logic [63:0] exp_rd;
    is_mem = (op == LOAD) || (op == STORE);
    is_st  = (op == STORE);
    exp_rd = (op == LOAD) ? ref_load(f3, alu, word) : 64'd0;
    valid_mem_i = 1'b1;
    opcode_mem_i = op; funct3_mem_i = f3; alu_out_mem_i = alu;
    rs2_data_mem_i = rs2; rd_addr_mem_i = rd; rd_en_mem_i = rden;
    chk("ready_idle", ready_mem_o, 1'b1);
    tick();
    valid_mem_i = 1'b0;
    alu_out_mem_i = {$urandom, $urandom}; rs2_data_mem_i = {$urandom, $urandom};
    rd_addr_mem_i = 5'($urandom); opcode_mem_i = 7'($urandom); funct3_mem_i = 3'($urandom);
    if (is_mem) begin
      for (int c = 0; c <= ack_dly; c++) begin
        chk("req", dmem_req_o, 1'b1);
        chk("we", dmem_we_o, is_st);
        chk("addr", dmem_addr_o, alu & ~64'h7);
        chk("strb", dmem_strb_o, is_st ? ref_strb(f3, alu) : 8'h00);
        if (is_st) chk("wdata", dmem_wdata_o, ref_wdata(f3, alu, rs2));
        chk("valid_wb_in_mem", valid_wb_o, 1'b0);
        chk("ready_in_mem", ready_mem_o, 1'b0);
        if (c == ack_dly) begin
          dmem_ack_i = 1'b1; dmem_rdata_i = word;
        end else begin
          dmem_rdata_i = {$urandom, $urandom};
        end
        tick();
      end
      dmem_ack_i = 1'b0;
      dmem_rdata_i = {$urandom, $urandom};
    end
    for (int s = 0; s <= stall; s++) begin
      chk("valid_wb", valid_wb_o, 1'b1);
      chk("req_in_send", dmem_req_o, 1'b0);
      chk("ready_in_send", ready_mem_o, 1'b0);
      chk("rd_addr_wb", rd_addr_wb_o, rd);
      chk("rd_en_wb", rd_en_wb_o, is_st ? 1'b0 : rden);
      chk("opcode_wb", opcode_wb_o, op);
      chk("funct3_wb", funct3_wb_o, f3);
      chk("alu_out_wb", alu_out_wb_o, alu);
      chk("rdata_wb", rdata_wb_o, exp_rd);
      valid_mem_i = (s < stall);
      ready_wb_i  = (s == stall);
      tick();
    end
    ready_wb_i = 1'b0;
    valid_mem_i = 1'b0;
    chk("valid_wb_done", valid_wb_o, 1'b0);
    chk("ready_done", ready_mem_o, 1'b1);
  endtask

  initial begin
    logic [63:0] b2b [4];
    logic [6:0]  rop;
    logic [2:0]  rf3;
    int          kind;

    rst_n = 1'b0; valid_mem_i = 1'b0; ready_wb_i = 1'b0; dmem_ack_i = 1'b0;
    alu_out_mem_i = '0; rs2_data_mem_i = '0; rd_addr_mem_i = '0; rd_en_mem_i = 1'b0;
    opcode_mem_i = '0; funct3_mem_i = '0; dmem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_mem_o, 1'b1);
    chk("rst_req", dmem_req_o, 1'b0);
    chk("rst_we", dmem_we_o, 1'b0);
    chk("rst_valid_wb", valid_wb_o, 1'b0);
    chk("rst_rd_en", rd_en_wb_o, 1'b0);
    chk("rst_alu", alu_out_wb_o, 64'd0);
    chk("rst_addr", dmem_addr_o, 64'd0);
    chk("rst_strb", dmem_strb_o, 8'd0);
    rst_n = 1'b1;
    tick();

    // ALU op passes straight through
    do_txn(OP, 3'b000, 64'h1234, 64'h0, 5'd5, 1'b1, 64'h0, 0, 0);
    // LB with sign extension, ack in the third request cycle
    do_txn(LOAD, F3_B, 64'h1003, 64'h0, 5'd7, 1'b1, 64'h00000000_80000000, 2, 0);
    // SW into the upper word, immediate ack
    do_txn(STORE, F3_W, 64'h2004, 64'hDEADBEEF, 5'd9, 1'b1, 64'h0, 0, 0);
    // LHU with a 4-cycle writeback stall
    do_txn(LOAD, F3_HU, 64'h10, 64'h0, 5'd3, 1'b1, 64'h12345678_9ABCFFFE, 0, 4);

    // Reset during MEM of an LD, then a stray ack in IDLE
    valid_mem_i = 1'b1; opcode_mem_i = LOAD; funct3_mem_i = F3_D;
    alu_out_mem_i = 64'h3000; rd_addr_mem_i = 5'd1; rd_en_mem_i = 1'b1;
    tick();
    valid_mem_i = 1'b0;
    chk("ld_req_before_rst", dmem_req_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("req_drop_async", dmem_req_o, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("ready_after_rst", ready_mem_o, 1'b1);
    chk("valid_wb_after_rst", valid_wb_o, 1'b0);
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    dmem_ack_i = 1'b0;
    chk("stray_ack_valid_wb", valid_wb_o, 1'b0);
    chk("stray_ack_req", dmem_req_o, 1'b0);
    chk("stray_ack_ready", ready_mem_o, 1'b1);

    // Back-to-back ALU ops: accept every second cycle, in order
    for (int i = 0; i < 4; i++) b2b[i] = {$urandom, $urandom};
    ready_wb_i = 1'b1;
    opcode_mem_i = OP_IMM; funct3_mem_i = 3'b000; rd_en_mem_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_mem_i = 1'b1; alu_out_mem_i = b2b[i]; rd_addr_mem_i = 5'(i + 10);
      chk("b2b_ready", ready_mem_o, 1'b1);
      tick();
      chk("b2b_valid", valid_wb_o, 1'b1);
      chk("b2b_ready_low", ready_mem_o, 1'b0);
      chk("b2b_alu", alu_out_wb_o, b2b[i]);
      chk("b2b_rd", rd_addr_wb_o, 5'(i + 10));
      if (i < 3) alu_out_mem_i = b2b[i+1];
      tick();
    end
    valid_mem_i = 1'b0; ready_wb_i = 1'b0;
    chk("b2b_idle", valid_wb_o, 1'b0);

    // Randomized mix
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        rop = LOAD; rf3 = 3'($urandom_range(0, 7));
      end else if (kind == 1) begin
        rop = STORE; rf3 = 3'($urandom_range(0, 3));
      end else begin
        rop = ($urandom_range(0, 1) == 1) ? OP : OP_IMM; rf3 = 3'($urandom);
      end
      do_txn(rop, rf3, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
             1'($urandom), {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
